// File: rtl/noc_in_arb_pkg.sv
// Shared types and helpers for the NoC data-in PIO arbiter: FSM state encoding,
// default word width and the round-robin pick function.
package noc_in_arb_pkg;

    localparam int NOC_DATA_W = 32;
    localparam int RR_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } arb_state_e;

    // One-hot pick of the first valid bit strictly after 'last', wrapping at n_req-1.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [2:0]            last,
        input logic [3:0]            n_req
    );
        logic [RR_MAX_REQ-1:0] pick;
        logic                  found;
        logic [3:0]            idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= RR_MAX_REQ; off++) begin
            idx = {1'b0, last} + 4'(off);
            if (idx >= n_req) begin
                idx = idx - n_req;
            end else begin
                idx = idx;
            end
            if ((4'(off) <= n_req) && !found && valid[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/noc_in_port_arbiter_rr.sv
// Combinational round-robin picker, reusable for any NoC shared resource.
// Grant is one-hot on the first valid requester after 'last', or zero when disabled.
module noc_rr_arbiter
    import noc_in_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                     enable,
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant
);

    logic [RR_MAX_REQ-1:0] valid_ext_s;
    logic [RR_MAX_REQ-1:0] pick_s;

    // Widen to the package helper width and gate the result.
    always_comb begin
        valid_ext_s             = '0;
        valid_ext_s[N_REQ-1:0]  = valid;
        pick_s                  = rr_pick(valid_ext_s, 3'(last), 4'(N_REQ));
        if (enable) begin
            grant = pick_s[N_REQ-1:0];
        end else begin
            grant = '0;
        end
    end

    if (N_REQ < RR_MAX_REQ) begin : g_hi
        logic unused_hi_s;
        assign unused_hi_s = ^pick_s[RR_MAX_REQ-1:N_REQ];
    end

endmodule

// File: rtl/noc_in_port_arbiter.sv
// Round-robin sequencer sharing the NoC data-in PIO between N_REQ requesters.
// Optional word-drop timeout in PRESENT is enabled with NOC_IN_ARB_TIMEOUT_EN.
module noc_in_port_arbiter
    import noc_in_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = NOC_DATA_W,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]        pio_word,
    output logic                     pio_valid,
    input  logic                     pio_ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_pulse
);

    localparam int         IDX_W    = $clog2(N_REQ);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [IDX_W-1:0]  last_grant_r;
    logic [3:0]        gap_cnt_r;
    logic [DATA_W-1:0] word_r;
    logic              valid_r;
    logic [IDX_W-1:0]  grant_id_r;
    logic              busy_r;
    logic              pulse_r;

    logic [N_REQ-1:0]  grant_s;
    logic              xfer_s;
    logic              tmo_hit_s;
    logic [DATA_W-1:0] sel_word_s;
    logic [IDX_W-1:0]  sel_idx_s;

    logic [DATA_W-1:0] word_nxt_s;
    logic              valid_nxt_s;
    logic [IDX_W-1:0]  grant_id_nxt_s;
    logic [IDX_W-1:0]  last_nxt_s;
    logic [3:0]        gap_nxt_s;
    logic              pulse_nxt_s;
    logic              busy_nxt_s;

    noc_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .enable (state_r == IDLE),
        .valid  (req_valid),
        .last   (last_grant_r),
        .grant  (grant_s)
    );

    assign req_ready = grant_s;
    assign xfer_s    = |(req_valid & grant_s);

    // Mux the granted requester's word and index (grant is one-hot or zero).
    always_comb begin
        sel_word_s = '0;
        sel_idx_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_word_s = sel_word_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
            sel_idx_s  = sel_idx_s | (IDX_W'(i) & {IDX_W{grant_s[i]}});
        end
    end

`ifdef NOC_IN_ARB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Counts completed PRESENT cycles; zero everywhere else so each entry starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == PRESENT) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign tmo_hit_s = (state_r == PRESENT) && (tmo_cnt_r == TMO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an ack beats a simultaneous timeout but both lead to GAP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = PRESENT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESENT: begin
                if (pio_ack || tmo_hit_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = PRESENT;
                end
            end
            GAP: begin
                if (gap_cnt_r <= 4'd1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values for the registered outputs and bookkeeping.
    always_comb begin
        word_nxt_s     = word_r;
        valid_nxt_s    = valid_r;
        grant_id_nxt_s = grant_id_r;
        last_nxt_s     = last_grant_r;
        gap_nxt_s      = gap_cnt_r;
        pulse_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    word_nxt_s     = sel_word_s;
                    valid_nxt_s    = 1'b1;
                    grant_id_nxt_s = sel_idx_s;
                    last_nxt_s     = sel_idx_s;
                end else begin
                    gap_nxt_s = 4'd0;
                end
            end
            PRESENT: begin
                if (pio_ack) begin
                    word_nxt_s  = '0;
                    valid_nxt_s = 1'b0;
                    gap_nxt_s   = GAP_LOAD;
                end else if (tmo_hit_s) begin
                    word_nxt_s  = '0;
                    valid_nxt_s = 1'b0;
                    gap_nxt_s   = GAP_LOAD;
                    pulse_nxt_s = 1'b1;
                end else begin
                    pulse_nxt_s = 1'b0;
                end
            end
            GAP: begin
                word_nxt_s  = '0;
                valid_nxt_s = 1'b0;
                gap_nxt_s   = gap_cnt_r - 4'd1;
            end
            default: begin
                word_nxt_s  = '0;
                valid_nxt_s = 1'b0;
                gap_nxt_s   = 4'd0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output and bookkeeping registers; last_grant resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r       <= '0;
            valid_r      <= 1'b0;
            grant_id_r   <= '0;
            last_grant_r <= IDX_W'(N_REQ - 1);
            gap_cnt_r    <= 4'd0;
            busy_r       <= 1'b0;
            pulse_r      <= 1'b0;
        end else begin
            word_r       <= word_nxt_s;
            valid_r      <= valid_nxt_s;
            grant_id_r   <= grant_id_nxt_s;
            last_grant_r <= last_nxt_s;
            gap_cnt_r    <= gap_nxt_s;
            busy_r       <= busy_nxt_s;
            pulse_r      <= pulse_nxt_s;
        end
    end

    assign pio_word      = word_r;
    assign pio_valid     = valid_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign timeout_pulse = pulse_r;

endmodule

// File: tb/tb_noc_in_port_arbiter.sv
// Directed scoreboard bench for noc_in_port_arbiter; timeout steps run when
// NOC_IN_ARB_TIMEOUT_EN is defined.
module tb_noc_in_port_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  pio_word;
    logic         pio_valid;
    logic         pio_ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_pulse;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    noc_in_port_arbiter #(
        .N_REQ          (4),
        .DATA_W         (32),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pio_word      (pio_word),
        .pio_valid     (pio_valid),
        .pio_ack       (pio_ack),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] word, input logic [1:0] id);
        exp_t e;
        e.word = word;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for pio_valid, then pop the scoreboard and compare.
    task automatic wait_valid(input string tag, output int lat);
        exp_t e;
        lat = 0;
        while (pio_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_wait_expired"}, 32'(lat >= 40), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_word"}, pio_word, e.word);
            check({tag, "_id"}, 32'(grant_id), 32'(e.id));
        end
    endtask

    task automatic pulse_ack();
        pio_ack = 1'b1;
        @(negedge clk);
        pio_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic saw_valid;
        logic saw_ready;
        logic saw_pulse;

        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        pio_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pio_valid", 32'(pio_valid), 32'd0);
        check("rst_pio_word", pio_word, 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_pulse), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Single request, 1-cycle latency, then a 2-cycle gap.
        req_data[31:0] = 32'hDEADBEEF;
        req_valid      = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        push_exp(32'hDEADBEEF, 2'd0);
        @(negedge clk);
        wait_valid("t1", lat);
        check("t1_latency", 32'(lat), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_in_present", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        pulse_ack();
        check("t1_gap1_valid", 32'(pio_valid), 32'd0);
        check("t1_gap1_word", pio_word, 32'd0);
        check("t1_gap1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_gap2_valid", 32'(pio_valid), 32'd0);
        check("t1_gap2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // All four requesting: rotation 0,1,2,3,0.
        do_reset();
        req_data  = {32'h13, 32'h12, 32'h11, 32'h10};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_exp(32'h10 + 32'(k % 4), 2'(k % 4));
        end
        #1;
        check("t2_ready_first", 32'(req_ready), 32'h1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            wait_valid($sformatf("t2_grant%0d", k), lat);
            check($sformatf("t2_ready_present%0d", k), 32'(req_ready), 32'h0);
            repeat (2) @(negedge clk);
            if (k == 4) begin
                req_valid = 4'b0000;
            end
            pulse_ack();
        end

        // Acks in GAP and IDLE do nothing.
        pio_ack = 1'b1;
        @(negedge clk);
        check("t3_gap_valid", 32'(pio_valid), 32'd0);
        check("t3_gap_busy", 32'(busy), 32'd1);
        check("t3_gap_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("t3_idle_valid", 32'(pio_valid), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_idle_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("t3_idle2_valid", 32'(pio_valid), 32'd0);
        check("t3_idle2_busy", 32'(busy), 32'd0);
        pio_ack = 1'b0;

        // Reset while holding a word; next grant restarts at requester 0.
        req_data[95:64] = 32'hA5A5A5A5;
        req_valid       = 4'b0100;
        #1;
        check("t4_ready", 32'(req_ready), 32'h4);
        push_exp(32'hA5A5A5A5, 2'd2);
        @(negedge clk);
        wait_valid("t4_hold", lat);
        reset     = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("t4_rst_word", pio_word, 32'd0);
        check("t4_rst_valid", 32'(pio_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        reset          = 1'b0;
        req_data[31:0] = 32'h000000C0;
        req_valid      = 4'b1111;
        #1;
        check("t4_ready_after_rst", 32'(req_ready), 32'h1);
        push_exp(32'h000000C0, 2'd0);
        @(negedge clk);
        wait_valid("t4_regrant", lat);
        req_valid = 4'b0000;
        pulse_ack();
        repeat (2) @(negedge clk);

        // Requester 2 pulses during requester 1's transfer and leaves before GAP ends.
        req_data[63:32] = 32'h00000111;
        req_data[95:64] = 32'h00000222;
        req_valid       = 4'b0010;
        push_exp(32'h00000111, 2'd1);
        @(negedge clk);
        wait_valid("t5_r1", lat);
        req_valid = 4'b0110;
        @(negedge clk);
        check("t5_ready_present", 32'(req_ready), 32'h0);
        pulse_ack();
        req_valid = 4'b0000;
        saw_valid = 1'b0;
        saw_ready = 1'b0;
        saw_pulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | pio_valid;
            saw_ready = saw_ready | (|req_ready);
            saw_pulse = saw_pulse | timeout_pulse;
        end
        check("t5_no_spurious_valid", 32'(saw_valid), 32'd0);
        check("t5_no_spurious_ready", 32'(saw_ready), 32'd0);
        check("t5_no_pulse", 32'(saw_pulse), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);

`ifdef NOC_IN_ARB_TIMEOUT_EN
        // No ack: drop after 8 PRESENT cycles.
        do_reset();
        req_data[31:0] = 32'h00000077;
        req_valid      = 4'b0001;
        push_exp(32'h00000077, 2'd0);
        @(negedge clk);
        wait_valid("t6_a", lat);
        req_valid = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t6_pulse_c%0d", k), 32'(timeout_pulse), 32'(k == 8));
            if (k == 8) begin
                check("t6_drop_valid", 32'(pio_valid), 32'd0);
                check("t6_drop_busy", 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);

        // Ack on the 8th PRESENT cycle wins over the timeout.
        req_valid = 4'b0001;
        push_exp(32'h00000077, 2'd0);
        @(negedge clk);
        wait_valid("t6_b", lat);
        req_valid = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t6b_nopulse_c%0d", k), 32'(timeout_pulse), 32'd0);
            if (k == 8) begin
                check("t6b_acked_valid", 32'(pio_valid), 32'd0);
            end
            pio_ack = (k == 7);
        end
        pio_ack = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_in_port_arbiter.md
Name: noc_in_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single 32-bit NoC data-in PIO `in_port` between N on-chip requesters.
- Captures one word from the granted requester and holds it stable on the PIO input together with a valid flag.
- The valid flag is wired to a separate 1-bit status PIO.
- Waits for the software consumer's acknowledge, inserts a quiet gap, then re-arbitrates.
- Sits between requesters (NoC receive ports, debug injectors) and the memory-mapped PIO read by the processor.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 32, word width; must match the PIO `in_port` width
- GAP_CYCLES, 2, cycles of `pio_valid`=0 and `pio_word`=0 after each ack (1..15)
- TIMEOUT_CYCLES, 1024, cycles allowed in PRESENT before the word is dropped (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester word available
- req_data  input  N_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- pio_word  output  DATA_W  word driven to the PIO `in_port`
- pio_valid  output  1  word-present flag for the status PIO
- pio_ack  input  1  single-cycle consumer acknowledge, from an output PIO edge
- grant_id  output  clog2(N_REQ)  index of the requester whose word is held
- busy  output  1  high in any state other than IDLE
- timeout_pulse  output  1  one-cycle drop indication (optional feature)

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered except req_ready.
- Reset values:
  - state = IDLE
  - pio_word = 0, pio_valid = 0, grant_id = 0, busy = 0, timeout_pulse = 0
  - last_grant = N_REQ-1, so requester 0 has first priority
  - gap and timeout counters = 0
- Reset asserted mid-operation discards the held word, returns to IDLE, and leaves no pending grant.
- IDLE:
  - req_ready is combinational. It is one-hot on the first asserted req_valid, searching upward from last_grant+1 and wrapping at N_REQ-1 → 0.
  - req_ready is all zeros when no request is valid, or when the state is not IDLE.
  - On a transfer: the next edge latches pio_word = req_data[i], sets pio_valid = 1, grant_id = i, last_grant = i, and moves to PRESENT.
  - Latency from a valid request in IDLE to pio_valid=1 is 1 cycle.
- PRESENT:
  - pio_word and pio_valid are held stable. req_valid changes are ignored.
  - On pio_ack=1, the next edge clears pio_valid and pio_word, loads the gap counter with GAP_CYCLES, and moves to GAP.
- GAP:
  - The counter decrements each cycle. When it reaches 1, the next state is IDLE.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- pio_ack is ignored in IDLE and GAP and never produces a grant.
- A requester that deasserts req_valid before being granted loses nothing; it is simply skipped.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- busy = (state != IDLE).

Optional Feature:
- Macro: NOC_IN_ARB_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to PRESENT and increments each PRESENT cycle.
  - If it reaches TIMEOUT_CYCLES with no ack, the word is dropped: timeout_pulse=1 for one cycle, and the block enters GAP exactly as if acked.
  - An ack in the same cycle as the timeout takes priority: normal GAP, no pulse.
- Undefined:
  - No counter logic is generated. timeout_pulse is tied to 0, and PRESENT waits indefinitely.

Decomposition:
- Package noc_in_arb_pkg holds:
  - state enum {IDLE, PRESENT, GAP}, 2-bit encoding
  - DATA_W default
  - function rr_pick(valid, last) returning a one-hot vector
- One natural sub-module: noc_rr_arbiter, a combinational round-robin picker parameterised on N_REQ. It is reusable for other NoC shared resources.

Test Plan:
- Reset then req_valid=4'b0001, req_data[0]=32'hDEADBEEF:
  - req_ready=4'b0001 same cycle
  - next cycle pio_valid=1, pio_word=32'hDEADBEEF, grant_id=0
  - pio_ack pulse → pio_valid=0 for exactly 2 cycles, then IDLE
- All four requesters held valid with data 32'h10..32'h13; ack 3 cycles after each valid:
  - grant order 0,1,2,3,0
  - pio_word sequence 10,11,12,13,10
- Ack in IDLE and in GAP (req_valid=0):
  - no req_ready, pio_valid stays 0, busy unchanged
- Reset asserted in PRESENT holding 32'hA5A5A5A5:
  - next cycle pio_word=0, pio_valid=0, busy=0
  - next grant goes to requester 0
- Requester 2 pulses req_valid while requester 1 is in PRESENT, then drops it before GAP ends:
  - requester 2 is never granted; no spurious pio_valid
- With NOC_IN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack:
  - timeout_pulse=1 exactly 8 cycles after pio_valid rises, then GAP
  - repeat with ack on cycle 8 → no pulse
